// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_NREQ   = 4;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: packed per-requester request fields,
// one-hot grant/ack back, and broadcast read data.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, ack, rdata
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational picker: first asserted request at or after `start`, wrapping modulo NREQ.
module arb_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic              found;
  logic [IDX_W-1:0]  pos;
  int unsigned       j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    j      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      pos = IDX_W'(j);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data RAM arbiter: IDLE/ACCESS/WAIT/DONE transaction per grant, optional lock bursts.
// MEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  win_q;
  logic [NREQ-1:0]   win_oh_q;
  logic [DATA_W-1:0] rdata_q;
  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  start;
  logic              arb_en;
  logic [NREQ-1:0]   gnt_c;
  logic [NREQ-1:0]   ack_c;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Pointer tracks the last fresh winner; locked re-grants never pass through IDLE so leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr_q <= IDX_W'(NREQ - 1);
    else if (arb_en) ptr_q <= pick_idx;
  end

  assign start = (ptr_q == IDX_W'(NREQ - 1)) ? '0 : ptr_q + IDX_W'(1);
`else
  assign start = '0;
`endif

  arb_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // State, winner and read-data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      win_oh_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (arb_en) begin
        win_q    <= pick_idx;
        win_oh_q <= pick_oh;
      end
      if (state_q == WAIT && !bus.we[win_q]) rdata_q <= mem_rdata;
    end
  end

  // Next-state logic; arbitration only happens on leaving IDLE
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = ACCESS;
          arb_en  = 1'b1;
        end
      end
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = (bus.lock[win_q] && bus.req[win_q]) ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM and handshake outputs decoded from state and registered winner
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gnt_c     = '0;
    ack_c     = '0;
    case (state_q)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = bus.we[win_q];
        mem_addr  = bus.addr[32'(win_q)*ADDR_W +: ADDR_W];
        mem_wdata = bus.wdata[32'(win_q)*DATA_W +: DATA_W];
        gnt_c     = win_oh_q;
      end
      WAIT:    gnt_c = win_oh_q;
      DONE:    ack_c = win_oh_q;
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_c;
  assign bus.ack   = ack_c;
  assign bus.rdata = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single accesses, a scoreboard on ack,
// and directed contention, lock-burst, mid-transaction reset and idle sequences.
module tb_mem_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] rdata;
  } sb_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  sb_t  sb[$];
  sb_t  e;
  vec_t vecs[6];
  logic [7:0] ram[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered single-port RAM: read-first, data valid the cycle after mem_en
  initial begin
    logic [7:0] tmp;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h55;
    ram[8'h3C] = 8'hA5;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        tmp = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        mem_rdata <= tmp;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && bus.ack != '0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: got %b, expected no ack", bus.ack);
      end else begin
        e = sb.pop_front();
        check("sb_ack", 32'(bus.ack), 32'(e.ack));
        check("sb_rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  task automatic set_slice(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.we[id]            = w;
    bus.addr[id*8 +: 8]   = a;
    bus.wdata[id*8 +: 8]  = d;
  endtask

  // One unlocked access from IDLE with cycle-exact latency checks
  task automatic run_vec(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.id;
    check("vec_idle_busy", 32'(busy), 0);
    set_slice(v.id, v.we, v.addr, v.wdata);
    bus.req = oh;
    sb.push_back('{ack: oh, rdata: v.exp_rdata});
    tick();
    check("vec_gnt", 32'(bus.gnt), 32'(oh));
    check("vec_mem_en", 32'(mem_en), 1);
    check("vec_mem_we", 32'(mem_we), 32'(v.we));
    check("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
    if (v.we) check("vec_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
    tick();
    check("vec_wait_en", 32'(mem_en), 0);
    check("vec_wait_gnt", 32'(bus.gnt), 32'(oh));
    tick();
    check("vec_ack", 32'(bus.ack), 32'(oh));
    check("vec_rdata", 32'(bus.rdata), 32'(v.exp_rdata));
    bus.req = '0;
    bus.we  = '0;
    tick();
    check("vec_back_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] cont_data[4];
    int         exp_id;
    int         k;
    int         last_cyc;

    cont_data[0] = 8'h75; cont_data[1] = 8'h74; cont_data[2] = 8'h77; cont_data[3] = 8'h76;
    vecs[0] = '{id: 1, we: 1'b0, addr: 8'h3C, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[1] = '{id: 0, we: 1'b1, addr: 8'h10, wdata: 8'h5A, exp_rdata: 8'hA5};
    vecs[2] = '{id: 0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[3] = '{id: 2, we: 1'b1, addr: 8'hFF, wdata: 8'hC3, exp_rdata: 8'h5A};
    vecs[4] = '{id: 1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hC3};
    vecs[5] = '{id: 3, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h55};

    reset     = 1'b0;
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: all four request continuously
    for (int i = 0; i < 4; i++) set_slice(i, 1'b0, 8'(8'h20 + i), 8'h00);
    bus.req  = 4'b1111;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
`ifdef MEM_ARB_RR_EN
      exp_id = g % 4;
`else
      exp_id = 0;
`endif
      sb.push_back('{ack: 4'(4'b0001 << exp_id), rdata: cont_data[exp_id]});
      k = 0;
      tick();
      while (!mem_en && k < 8) begin
        tick();
        k++;
      end
      check("cont_timeout", 32'(mem_en), 1);
      if (g > 0) check("cont_period", 32'(cyc - last_cyc), 4);
      last_cyc = cyc;
      check("cont_gnt", 32'(bus.gnt), 32'(4'b0001 << exp_id));
      check("cont_addr", 32'(mem_addr), 32'(8'h20 + exp_id));
      tick();
      tick();
      if (g == 4) bus.req = '0;
    end
    tick();
    check("cont_idle", 32'(busy), 0);

    // Lock burst by requester 2 while requester 0 waits
    set_slice(2, 1'b0, 8'h30, 8'h00);
    set_slice(0, 1'b0, 8'h31, 8'h00);
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    for (int i = 0; i < 3; i++) sb.push_back('{ack: 4'b0100, rdata: 8'h65});
    tick();
    check("lock_gnt0", 32'(bus.gnt), 32'(4'b0100));
    bus.req = 4'b0101;
    sb.push_back('{ack: 4'b0001, rdata: 8'h64});
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        tick();
        check("lock_regnt", 32'(bus.gnt), 32'(4'b0100));
        check("lock_regnt_en", 32'(mem_en), 1);
      end
      tick();
      tick();
      check("lock_ack", 32'(bus.ack), 32'(4'b0100));
    end
    bus.req  = 4'b0001;
    bus.lock = '0;
    tick();
    check("lock_release_idle", 32'(busy), 0);
    tick();
    check("lock_then_gnt0", 32'(bus.gnt), 32'(4'b0001));
    tick();
    tick();
    check("lock_then_ack0", 32'(bus.ack), 32'(4'b0001));
    bus.req = '0;
    tick();

    // Reset asserted while a read is in WAIT
    set_slice(3, 1'b0, 8'h22, 8'h00);
    bus.req = 4'b1000;
    tick();
    check("rw_gnt", 32'(bus.gnt), 32'(4'b1000));
    tick();
    reset = 1'b0;
    #1;
    check("rw_mem_en", 32'(mem_en), 0);
    check("rw_gnt_clr", 32'(bus.gnt), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_rdata", 32'(bus.rdata), 0);
    bus.req = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) set_slice(i, 1'b0, 8'(8'h20 + i), 8'h00);
    bus.req = 4'b1111;
    sb.push_back('{ack: 4'b0001, rdata: 8'h75});
    tick();
    check("rw_first_gnt", 32'(bus.gnt), 32'(4'b0001));
    tick();
    tick();
    check("rw_first_ack", 32'(bus.ack), 32'(4'b0001));
    bus.req = '0;
    tick();

    // Idle: nothing requested
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_mem_en", 32'(mem_en), 0);
    end

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
